// File: rtl/esc_cmd_sequencer_pkg.sv
// Shared types and constants for the ESC command sequencer.
package esc_pkg;

   localparam int NUM_MOTORS = 4;
   localparam int SPEED_W    = 11;

   // Sequencer phases: wait for frame, slew one motor per cycle, strobe ESCs
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SLEW = 2'd1,
      WRT  = 2'd2
   } state_t;

   typedef logic [1:0] motor_idx_t;

   // Motor slots, also the order in which they are slewed
   localparam motor_idx_t MOTOR_FRNT = 2'd0;
   localparam motor_idx_t MOTOR_BCK  = 2'd1;
   localparam motor_idx_t MOTOR_LFT  = 2'd2;
   localparam motor_idx_t MOTOR_RGHT = 2'd3;

endpackage

// File: rtl/esc_cmd_sequencer_slew_step.sv
// Combinational rate limiter: moves cur toward tgt by at most step.
module slew_step
   import esc_pkg::*;
(
   input  logic [SPEED_W-1:0] cur,
   input  logic [SPEED_W-1:0] tgt,
   input  logic [SPEED_W-1:0] step,
   output logic [SPEED_W-1:0] nxt
);

   logic [SPEED_W:0] up_lim;
   logic [SPEED_W:0] dn_lim;

   // Compare in one extra bit so cur+step and tgt+step cannot wrap; the chosen
   // result is computed at native width because it is then known to be in range
   always_comb begin
      up_lim = {1'b0, cur} + {1'b0, step};
      dn_lim = {1'b0, tgt} + {1'b0, step};
      nxt    = tgt;
      if ({1'b0, tgt} > up_lim) begin
         nxt = cur + step;
      end else if (dn_lim < {1'b0, cur}) begin
         nxt = cur - step;
      end
   end

endmodule

// File: rtl/esc_cmd_sequencer.sv
// Frame-synchronous, rate-limited SPEED sequencer for four ESC PWM interfaces.
module esc_cmd_sequencer
   import esc_pkg::*;
#(
   parameter int                 FRAME_CNT_W = 20,
   parameter logic [SPEED_W-1:0] SLEW_STEP   = 11'd64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_vld,
   input  logic [SPEED_W-1:0] frnt_cmd,
   input  logic [SPEED_W-1:0] bck_cmd,
   input  logic [SPEED_W-1:0] lft_cmd,
   input  logic [SPEED_W-1:0] rght_cmd,
   input  logic               motors_off,
   output logic [SPEED_W-1:0] frnt_spd,
   output logic [SPEED_W-1:0] bck_spd,
   output logic [SPEED_W-1:0] lft_spd,
   output logic [SPEED_W-1:0] rght_spd,
   output logic               wrt
);

   state_t                   state_q, state_d;
   motor_idx_t               idx_q, idx_d;
   logic [FRAME_CNT_W-1:0]   cnt_q, cnt_d;
   logic                     moff_q, moff_d;
   logic [SPEED_W-1:0]       tgt_q  [NUM_MOTORS];
   logic [SPEED_W-1:0]       tgt_d  [NUM_MOTORS];
   logic [SPEED_W-1:0]       snap_q [NUM_MOTORS];
   logic [SPEED_W-1:0]       snap_d [NUM_MOTORS];
   logic [SPEED_W-1:0]       spd_q  [NUM_MOTORS];
   logic [SPEED_W-1:0]       spd_d  [NUM_MOTORS];
   logic [SPEED_W-1:0]       step_cur;
   logic [SPEED_W-1:0]       step_tgt;
   logic [SPEED_W-1:0]       step_nxt;

   // One limiter serves all motors; the slew index picks which one this cycle
   assign step_cur = spd_q[idx_q];
   assign step_tgt = snap_q[idx_q];

   slew_step u_slew_step (
      .cur  (step_cur),
      .tgt  (step_tgt),
      .step (SLEW_STEP),
      .nxt  (step_nxt)
   );

   assign frnt_spd = spd_q[MOTOR_FRNT];
   assign bck_spd  = spd_q[MOTOR_BCK];
   assign lft_spd  = spd_q[MOTOR_LFT];
   assign rght_spd = spd_q[MOTOR_RGHT];
   assign wrt      = (state_q == WRT);

   // Next-state: target capture, frame FSM, and the motors_off override last
   // so it beats both a same-cycle command and any in-flight slew
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q + FRAME_CNT_W'(1);
      moff_d  = motors_off;
      tgt_d   = tgt_q;
      snap_d  = snap_q;
      spd_d   = spd_q;

      if (cmd_vld) begin
         tgt_d[MOTOR_FRNT] = frnt_cmd;
         tgt_d[MOTOR_BCK]  = bck_cmd;
         tgt_d[MOTOR_LFT]  = lft_cmd;
         tgt_d[MOTOR_RGHT] = rght_cmd;
      end

      case (state_q)
         IDLE: begin
            if (cnt_q == {FRAME_CNT_W{1'b1}}) begin
               state_d = SLEW;
               idx_d   = MOTOR_FRNT;
               snap_d  = tgt_q;
            end
         end
         SLEW: begin
            spd_d[idx_q] = step_nxt;
            if (idx_q == MOTOR_RGHT) begin
               state_d = WRT;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end
         WRT:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (motors_off) begin
         for (int i = 0; i < NUM_MOTORS; i++) begin
            tgt_d[i]  = '0;
            snap_d[i] = '0;
            spd_d[i]  = '0;
         end
         if (!moff_q) begin
            state_d = WRT;
            idx_d   = MOTOR_FRNT;
            cnt_d   = '0;
         end
      end
   end

   // State, counter and all speed registers; async reset kills any frame in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= MOTOR_FRNT;
         cnt_q   <= '0;
         moff_q  <= 1'b0;
         for (int i = 0; i < NUM_MOTORS; i++) begin
            tgt_q[i]  <= '0;
            snap_q[i] <= '0;
            spd_q[i]  <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         moff_q  <= moff_d;
         for (int i = 0; i < NUM_MOTORS; i++) begin
            tgt_q[i]  <= tgt_d[i];
            snap_q[i] <= snap_d[i];
            spd_q[i]  <= spd_d[i];
         end
      end
   end

endmodule

// File: tb/tb_esc_cmd_sequencer.sv
// Directed scoreboard bench for esc_cmd_sequencer with a 256-cycle frame.
module tb_esc_cmd_sequencer;

   localparam int          FRAME_CNT_W = 8;
   localparam logic [10:0] SLEW_STEP   = 11'd64;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_vld;
   logic [10:0] frnt_cmd, bck_cmd, lft_cmd, rght_cmd;
   logic        motors_off;
   logic [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;
   logic        wrt;

   logic [43:0] expQ[$];
   int          errors = 0;
   int          checks = 0;
   int          gap;
   int          wrtSeen;

   esc_cmd_sequencer #(
      .FRAME_CNT_W (FRAME_CNT_W),
      .SLEW_STEP   (SLEW_STEP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_vld    (cmd_vld),
      .frnt_cmd   (frnt_cmd),
      .bck_cmd    (bck_cmd),
      .lft_cmd    (lft_cmd),
      .rght_cmd   (rght_cmd),
      .motors_off (motors_off),
      .frnt_spd   (frnt_spd),
      .bck_spd    (bck_spd),
      .lft_spd    (lft_spd),
      .rght_spd   (rght_spd),
      .wrt        (wrt)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [43:0] obs, input logic [43:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pushFrame(input logic [10:0] f, input logic [10:0] b,
                            input logic [10:0] l, input logic [10:0] r);
      expQ.push_back({f, b, l, r});
   endtask

   // Drive a one-cycle command from a negedge
   task automatic applyStimulus(input logic [10:0] f, input logic [10:0] b,
                                input logic [10:0] l, input logic [10:0] r);
      frnt_cmd = f;
      bck_cmd  = b;
      lft_cmd  = l;
      rght_cmd = r;
      cmd_vld  = 1'b1;
      @(negedge clk);
      cmd_vld  = 1'b0;
   endtask

   // Negedges until wrt is seen high, or -1 if the bound expires
   task automatic waitWrt(output int n);
      n = -1;
      for (int i = 1; i <= 1000; i++) begin
         @(negedge clk);
         if (wrt === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   // Wait for the next wrt and compare the four speeds with the oldest queued frame
   task automatic checkOutput(input string tag, output int n);
      logic [43:0] exp;
      waitWrt(n);
      if (n < 0) begin
         check({tag, "_timeout"}, {43'b0, wrt}, 44'd1);
      end else if (expQ.size() == 0) begin
         check({tag, "_sb_empty"}, 44'(expQ.size()), 44'd1);
      end else begin
         exp = expQ.pop_front();
         check(tag, {frnt_spd, bck_spd, lft_spd, rght_spd}, exp);
      end
   endtask

   // One-cycle motors_off pulse from a negedge; zeros and wrt must appear right after
   task automatic pulseMotorsOff(input string tag);
      motors_off = 1'b1;
      @(negedge clk);
      motors_off = 1'b0;
      check({tag, "_spd"}, {frnt_spd, bck_spd, lft_spd, rght_spd}, 44'd0);
      check({tag, "_wrt"}, {43'b0, wrt}, 44'd1);
   endtask

   initial begin
      rst        = 1'b1;
      cmd_vld    = 1'b0;
      motors_off = 1'b0;
      frnt_cmd   = '0;
      bck_cmd    = '0;
      lft_cmd    = '0;
      rght_cmd   = '0;

      repeat (3) @(negedge clk);
      check("reset_spd", {frnt_spd, bck_spd, lft_spd, rght_spd}, 44'd0);
      check("reset_wrt", {43'b0, wrt}, 44'd0);

      // Release at a negedge; that partial cycle counts as cycle 1, so wrt in cycle 261
      // is seen at the 260th following negedge
      rst = 1'b0;
      pushFrame(0, 0, 0, 0);
      checkOutput("first_frame", gap);
      check("first_wrt_cycle", 44'(gap + 1), 44'd261);
      pushFrame(0, 0, 0, 0);
      checkOutput("second_frame", gap);
      check("frame_period", 44'(gap), 44'd256);

      // Ramp frnt from 0 to 0x400 in 64-count steps, then hold
      applyStimulus(11'h400, 0, 0, 0);
      for (int k = 1; k <= 16; k++) pushFrame(11'(64 * k), 0, 0, 0);
      pushFrame(11'h400, 0, 0, 0);
      for (int k = 1; k <= 17; k++) checkOutput($sformatf("ramp_up_%0d", k), gap);

      // Small move within one step lands exactly
      applyStimulus(11'h3E0, 0, 0, 0);
      pushFrame(11'h3E0, 0, 0, 0);
      checkOutput("within_step", gap);

      // Climb to 0x7D0, then top out at 0x7FF without wrapping
      applyStimulus(11'h7D0, 0, 0, 0);
      for (int k = 1; k <= 15; k++) pushFrame(11'h3E0 + 11'(64 * k), 0, 0, 0);
      pushFrame(11'h7D0, 0, 0, 0);
      for (int k = 1; k <= 16; k++) checkOutput($sformatf("ramp_hi_%0d", k), gap);
      applyStimulus(11'h7FF, 11'h030, 0, 0);
      pushFrame(11'h7FF, 11'h030, 0, 0);
      checkOutput("no_overflow", gap);
      applyStimulus(11'h7FF, 11'h000, 0, 0);
      pushFrame(11'h7FF, 11'h000, 0, 0);
      checkOutput("no_underflow", gap);

      // motors_off from full speed; counter restarts so next wrt is 260 negedges later
      pulseMotorsOff("moff_full");
      pushFrame(0, 0, 0, 0);
      checkOutput("moff_full_frame", gap);
      check("moff_frame_gap", 44'(gap), 44'd260);

      // motors_off mid-ramp at 0x200; later frames stay zero with no new command
      applyStimulus(11'h400, 0, 0, 0);
      for (int k = 1; k <= 8; k++) pushFrame(11'(64 * k), 0, 0, 0);
      for (int k = 1; k <= 8; k++) checkOutput($sformatf("ramp_mid_%0d", k), gap);
      pulseMotorsOff("moff_mid");
      pushFrame(0, 0, 0, 0);
      pushFrame(0, 0, 0, 0);
      checkOutput("moff_hold_1", gap);
      checkOutput("moff_hold_2", gap);
      check("moff_hold_period", 44'(gap), 44'd256);

      // Command lands at cycle C+2 of the next frame: current frame unaffected
      repeat (253) @(negedge clk);
      check("slew_no_wrt", {43'b0, wrt}, 44'd0);
      applyStimulus(0, 11'h100, 0, 0);
      pushFrame(0, 0, 0, 0);
      pushFrame(0, 11'd64, 0, 0);
      checkOutput("slew_cmd_cur", gap);
      checkOutput("slew_cmd_next", gap);

      // Reset at C+3 (bck just stepped to 128): outputs clear at once, frame aborted
      repeat (254) @(negedge clk);
      check("pre_rst_bck", {33'b0, bck_spd}, 44'd128);
      rst = 1'b1;
      #1;
      check("rst_async_spd", {frnt_spd, bck_spd, lft_spd, rght_spd}, 44'd0);
      wrtSeen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (wrt === 1'b1) wrtSeen++;
      end
      check("rst_no_wrt", 44'(wrtSeen), 44'd0);
      rst = 1'b0;
      pushFrame(0, 0, 0, 0);
      checkOutput("post_rst_frame", gap);
      check("post_rst_wrt_cycle", 44'(gap + 1), 44'd261);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/esc_cmd_sequencer.md
# esc_cmd_sequencer

Sits directly upstream of the four ESC PWM interfaces; converts the flight controller's per-motor target speeds into rate-limited, frame-synchronous SPEED updates. Once per update frame it steps each motor's output toward its target by at most one slew step, then pulses a single shared `wrt` so all ESCs latch new SPEED values together. Also provides an immediate all-motors-off path.

## Interface
- `FRAME_CNT_W`, 20: update frame is 2^FRAME_CNT_W clocks.
- `SLEW_STEP`, 11'd64: max change per motor per frame, unsigned.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_vld`  in  1  one-cycle pulse; latch the four `*_cmd` inputs as new targets.
- `frnt_cmd`, `bck_cmd`, `lft_cmd`, `rght_cmd`  in  11 each  unsigned target speeds.
- `motors_off`  in  1  level; force all targets and outputs to 0.
- `frnt_spd`, `bck_spd`, `lft_spd`, `rght_spd`  out  11 each  registered SPEED to ESCs.
- `wrt`  out  1  one-cycle pulse; all ESCs latch `*_spd`.

## Operation
- Target regs (4 × 11 b) load on `cmd_vld`; independent of FSM state.
- Free-running frame counter, FRAME_CNT_W bits, 0 → 2^W−1, wraps.
- FSM states: IDLE, SLEW, WRT.
  - IDLE: on counter wrap → SLEW, motor index = 0; snapshot all four targets into working copies.
  - SLEW: one motor per cycle, order frnt, bck, lft, rght; update that motor's `*_spd` from snapshot; after rght → WRT.
  - WRT: `wrt`=1 for exactly one cycle → IDLE.
- Step rule (cur, tgt unsigned 11 b, arithmetic in 12 b): tgt > cur+SLEW_STEP → cur+SLEW_STEP; tgt+SLEW_STEP < cur → cur−SLEW_STEP; else tgt. Never wraps, never exceeds 0x7FF or goes below 0.
- `motors_off` asserted (any state): next edge clears targets, snapshots, all `*_spd`; FSM → WRT; frame counter → 0. While held, `wrt` pulses once only (at assertion) plus normally each frame with zeros.
- `cmd_vld` with `motors_off` in same cycle: `motors_off` wins, command discarded.
- `cmd_vld` during SLEW: targets update, snapshot unaffected; new values apply next frame.

## Timing
- Reset values: all `*_spd` = 0, `wrt` = 0, FSM = IDLE, counter = 0, targets = 0.
- Counter wrap at cycle C: SLEW at C+1..C+4 (`*_spd` change one per cycle), `wrt` high at cycle C+5.
- `*_spd` stable from `wrt` until next frame's SLEW; every `wrt` presents a coherent set of four values.
- `motors_off` sampled at edge E: `*_spd` = 0 and `wrt` = 1 at E+1.
- `rst` mid-SLEW: outputs 0 immediately (async), no `wrt` issued for the aborted frame.
- Ramp from 0 to tgt takes ceil(tgt/SLEW_STEP) frames.

## Structure
- Package `esc_pkg`: `NUM_MOTORS` = 4, `SPEED_W` = 11, FSM state enum typedef, 2-bit motor index typedef.
- Sub-module `slew_step`: combinational, inputs cur, tgt, step → next value per step rule; single instance shared across motors via index mux.
- Top holds counter, FSM, target/snapshot/output registers.

## Test plan
Bench uses FRAME_CNT_W = 8, SLEW_STEP = 64.
- Reset release, no commands → all `*_spd` = 0, first `wrt` exactly 261 cycles after reset deassertion (256 + 5), then every 256 cycles.
- `cmd_vld` frnt_cmd = 0x400, others 0 → frnt_spd = 64, 128, … at successive `wrt`, reaches 0x400 on 16th frame and holds; others stay 0.
- From frnt_spd = 0x400, cmd 0x3E0 → next frame 0x3E0 (within step); cmd 0x7FF from 0x7D0 → 0x7FF, no overflow; from 0x030 cmd 0 → 0, no underflow.
- `motors_off` pulsed mid-ramp (frnt_spd = 0x200) → next cycle all `*_spd` = 0, `wrt` = 1; later frames stay 0 until new `cmd_vld`.
- `cmd_vld` (bck_cmd = 0x100) issued during SLEW at cycle C+2 → current frame's bck_spd unchanged; bck_spd = 64 at following frame's `wrt`.
- `rst` asserted at C+3 → `*_spd` = 0 immediately, no `wrt` at C+5; normal framing resumes 261 cycles after release.
